// File: rtl/matrix_scan_ctrl.sv
// Row-multiplexed scan controller for an 8x8 RGB matrix with a double-buffered framebuffer.
// The back buffer takes pixel writes and clears; the front buffer is scanned to the pins.
module matrix_scan_ctrl #(
  parameter int unsigned SCAN_DIV  = 5000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic       SYS_CLK,
  input  logic       RST,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [2:0] wr_col,
  input  logic [2:0] wr_rgb,
  input  logic       clr,
  input  logic       swap_req,
  input  logic       blank,
  output logic [7:0] LedR,
  output logic [7:0] LedG,
  output logic [7:0] LedB,
  output logic [2:0] comm,
  output logic       enable,
  output logic       frame_start,
  output logic       swap_ack,
  output logic       busy
);

  localparam int unsigned   PW       = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] LastCnt  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BlankCnt = PW'(BLANK_CYC);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    row_q, row_d;
  logic          fb_sel_q, fb_sel_d;
  logic          pending_q, pending_d;
  logic          busy_q, busy_d;
  logic [2:0]    clr_row_q, clr_row_d;
  // Indexed [buffer][plane R,G,B][row]; bit position within a row is the column.
  logic [7:0]    fb_q [2][3][8];
  logic [7:0]    fb_d [2][3][8];
  logic [7:0]    led_q [3];
  logic [7:0]    led_d [3];
  logic          enable_q, enable_d;
  logic          frame_start_q, frame_start_d;
  logic          swap_ack_q, swap_ack_d;

  logic slot_end, wrap, do_swap, back_sel, show;

  always_comb begin
    slot_end = (presc_q == LastCnt);
    wrap     = slot_end && (row_q == 3'd7);
    do_swap  = wrap && pending_q && !busy_q;
    back_sel = ~fb_sel_q;

    presc_d   = slot_end ? '0 : presc_q + 1'b1;
    row_d     = slot_end ? row_q + 3'd1 : row_q;
    fb_sel_d  = do_swap ? ~fb_sel_q : fb_sel_q;
    pending_d = swap_req | (pending_q & ~do_swap);

    fb_d      = fb_q;
    busy_d    = busy_q;
    clr_row_d = clr_row_q;
    if (busy_q) begin
      for (int p = 0; p < 3; p++) begin
        fb_d[back_sel][p][clr_row_q] = '0;
      end
      clr_row_d = clr_row_q + 3'd1;
      if (clr_row_q == 3'd7) begin
        busy_d = 1'b0;
      end
    end else begin
      if (clr) begin
        busy_d    = 1'b1;
        clr_row_d = '0;
      end
      // A write on the swap cycle still lands in the outgoing back buffer, which becomes front.
      if (wr_en) begin
        fb_d[back_sel][0][wr_row][wr_col] = wr_rgb[2];
        fb_d[back_sel][1][wr_row][wr_col] = wr_rgb[1];
        fb_d[back_sel][2][wr_row][wr_col] = wr_rgb[0];
      end
    end

    show     = (presc_q >= BlankCnt) && !blank;
    enable_d = show;
    for (int p = 0; p < 3; p++) begin
      led_d[p] = show ? ~fb_q[fb_sel_q][p][row_q] : 8'hFF;
    end
    frame_start_d = wrap;
    swap_ack_d    = do_swap;
  end

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      presc_q       <= '0;
      row_q         <= '0;
      fb_sel_q      <= 1'b0;
      pending_q     <= 1'b0;
      busy_q        <= 1'b0;
      clr_row_q     <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int p = 0; p < 3; p++) begin
          for (int r = 0; r < 8; r++) begin
            fb_q[b][p][r] <= '0;
          end
        end
      end
      for (int p = 0; p < 3; p++) begin
        led_q[p] <= 8'hFF;
      end
      enable_q      <= 1'b0;
      frame_start_q <= 1'b0;
      swap_ack_q    <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      row_q         <= row_d;
      fb_sel_q      <= fb_sel_d;
      pending_q     <= pending_d;
      busy_q        <= busy_d;
      clr_row_q     <= clr_row_d;
      fb_q          <= fb_d;
      led_q         <= led_d;
      enable_q      <= enable_d;
      frame_start_q <= frame_start_d;
      swap_ack_q    <= swap_ack_d;
    end
  end

  assign LedR        = led_q[0];
  assign LedG        = led_q[1];
  assign LedB        = led_q[2];
  assign comm        = row_q;
  assign enable      = enable_q;
  assign frame_start = frame_start_q;
  assign swap_ack    = swap_ack_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Self-checking bench for matrix_scan_ctrl with SCAN_DIV=8, BLANK_CYC=2 (8-cycle row slots,
// 64-cycle frames). Expected scan timing is derived from the cycle count since reset release.
module tb_matrix_scan_ctrl;

  logic       SYS_CLK = 1'b0;
  logic       RST     = 1'b1;
  logic       wr_en   = 1'b0;
  logic [2:0] wr_row  = '0;
  logic [2:0] wr_col  = '0;
  logic [2:0] wr_rgb  = '0;
  logic       clr     = 1'b0;
  logic       swap_req = 1'b0;
  logic       blank   = 1'b0;
  logic [7:0] LedR, LedG, LedB;
  logic [2:0] comm;
  logic       enable, frame_start, swap_ack, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n        = 0;

  typedef struct {
    logic [2:0] row;
    logic [2:0] col;
    logic [2:0] rgb;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } vec_t;

  typedef struct {
    logic [2:0]  comm;
    logic        en;
    logic        fs;
    logic [23:0] led;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[5];

  matrix_scan_ctrl #(
    .SCAN_DIV (8),
    .BLANK_CYC(2)
  ) dut (
    .SYS_CLK    (SYS_CLK),
    .RST        (RST),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .wr_rgb     (wr_rgb),
    .clr        (clr),
    .swap_req   (swap_req),
    .blank      (blank),
    .LedR       (LedR),
    .LedG       (LedG),
    .LedB       (LedB),
    .comm       (comm),
    .enable     (enable),
    .frame_start(frame_start),
    .swap_ack   (swap_ack),
    .busy       (busy)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  // Posedges since reset release.
  always @(posedge SYS_CLK or negedge RST) begin
    if (!RST) n <= 0;
    else      n <= n + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic align(input int m, input int v);
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      if (n % m == v) ok = 1;
    end
    chk("align_reached", ok, 1);
  endtask

  task automatic do_clear();
    bit ok = 0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (!busy) ok = 1;
    end
    chk("clear_done", ok, 1);
  endtask

  task automatic wait_fs(output logic ack);
    bit ok = 0;
    ack = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge SYS_CLK);
      if (frame_start) begin
        ok  = 1;
        ack = swap_ack;
      end
    end
    chk("frame_start_seen", ok, 1);
  endtask

  task automatic push_rows(input logic [2:0] row, input logic [23:0] led);
    for (int r = 0; r < 8; r++) begin
      exp_t e;
      e.comm = 3'(r);
      e.en   = 1'b1;
      e.fs   = 1'b0;
      e.led  = (3'(r) == row) ? led : 24'hFFFFFF;
      sb_q.push_back(e);
    end
  endtask

  // Sample the middle of each row slot of one frame, in order, against the queued expectations.
  task automatic check_rows(input string tag);
    for (int r = 0; r < 8; r++) begin
      bit   ok = 0;
      exp_t e;
      for (int i = 0; i < 100 && !ok; i++) begin
        @(negedge SYS_CLK);
        if ((n / 8) % 8 == r && n % 8 == 4) ok = 1;
      end
      chk($sformatf("%s row%0d slot_found", tag, r), ok, 1);
      chk($sformatf("%s row%0d queue_nonempty", tag, r), sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk($sformatf("%s row%0d comm", tag, r), comm, e.comm);
        chk($sformatf("%s row%0d enable", tag, r), enable, e.en);
        chk($sformatf("%s row%0d led_rgb", tag, r), {LedR, LedG, LedB}, e.led);
      end
    end
  endtask

  task automatic check_scan(input int cycles, input bit blank_exp);
    for (int i = 0; i < cycles; i++) begin
      exp_t e;
      tick();
      e.comm = 3'((n / 8) % 8);
      e.en   = !blank_exp && (((n - 1) % 8) >= 2);
      e.fs   = (n % 64 == 0);
      e.led  = 24'hFFFFFF;
      sb_q.push_back(e);
      @(negedge SYS_CLK);
      e = sb_q.pop_front();
      chk($sformatf("scan n=%0d comm", n), comm, e.comm);
      chk($sformatf("scan n=%0d enable", n), enable, e.en);
      chk($sformatf("scan n=%0d frame_start", n), frame_start, e.fs);
      chk($sformatf("scan n=%0d led_rgb", n), {LedR, LedG, LedB}, e.led);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic ack;
    do_clear();
    wr_row = v.row;
    wr_col = v.col;
    wr_rgb = v.rgb;
    wr_en  = 1'b1;
    push_rows(v.row, {v.r, v.g, v.b});
    tick();
    wr_en = 1'b0;
    align(8, 4);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    wait_fs(ack);
    chk("vec swap_ack", ack, 1);
    check_rows($sformatf("vec(%0d,%0d,%b)", v.row, v.col, v.rgb));
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack;
    int   busy_cnt;
    int   acks;
    bit   fs_seen;

    vecs[0] = '{3'd2, 3'd3, 3'b010, 8'hFF, 8'hF7, 8'hFF};
    vecs[1] = '{3'd5, 3'd0, 3'b100, 8'hFE, 8'hFF, 8'hFF};
    vecs[2] = '{3'd7, 3'd7, 3'b001, 8'hFF, 8'hFF, 8'h7F};
    vecs[3] = '{3'd0, 3'd6, 3'b111, 8'hBF, 8'hBF, 8'hBF};
    vecs[4] = '{3'd4, 3'd1, 3'b110, 8'hFD, 8'hFD, 8'hFF};

    #1 RST = 1'b0;
    #11;
    chk("reset LedR", LedR, 8'hFF);
    chk("reset LedG", LedG, 8'hFF);
    chk("reset LedB", LedB, 8'hFF);
    chk("reset enable", enable, 0);
    chk("reset comm", comm, 0);
    chk("reset frame_start", frame_start, 0);
    chk("reset swap_ack", swap_ack, 0);
    chk("reset busy", busy, 0);
    @(negedge SYS_CLK);
    RST = 1'b1;

    // Empty buffers: buses stay FF; enable follows the blanking window only.
    check_scan(70, 1'b0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Clear overlapping the wrap defers the swap by one frame; writes while busy are dropped.
    wr_row = 3'd0; wr_col = 3'd0; wr_rgb = 3'b111; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    align(64, 60);
    clr = 1'b1;
    swap_req = 1'b1;
    tick();
    clr = 1'b0;
    swap_req = 1'b0;
    busy_cnt = 0;
    fs_seen  = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy) busy_cnt++;
      if (frame_start) begin
        fs_seen = 1;
        chk("deferred swap_ack", swap_ack, 0);
      end
      wr_en  = (i == 3);
      wr_row = 3'd3; wr_col = 3'd3; wr_rgb = 3'b111;
      tick();
    end
    wr_en = 1'b0;
    chk("clear busy cycles", busy_cnt, 8);
    chk("wrap during clear seen", fs_seen, 1);
    wait_fs(ack);
    chk("deferred swap then acked", ack, 1);
    push_rows(3'd0, 24'hFFFFFF);
    check_rows("after clear");

    // Write on the exact swap cycle is displayed.
    do_clear();
    align(64, 40);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    align(64, 63);
    wr_row = 3'd5; wr_col = 3'd0; wr_rgb = 3'b100; wr_en = 1'b1;
    push_rows(3'd5, {8'hFE, 8'hFF, 8'hFF});
    tick();
    wr_en = 1'b0;
    chk("simul frame_start", frame_start, 1);
    chk("simul swap_ack", swap_ack, 1);
    check_rows("simul");

    // Blank held for over a frame: dark, scan cadence unchanged.
    blank = 1'b1;
    check_scan(72, 1'b1);
    @(negedge SYS_CLK);
    blank = 1'b0;
    push_rows(3'd5, {8'hFE, 8'hFF, 8'hFF});
    check_rows("unblank");

    // Asynchronous reset on the fourth busy cycle with a swap pending.
    align(8, 4);
    clr = 1'b1;
    swap_req = 1'b1;
    tick();
    clr = 1'b0;
    swap_req = 1'b0;
    tick();
    tick();
    tick();
    chk("busy before reset", busy, 1);
    #2 RST = 1'b0;
    #1;
    chk("async reset led_rgb", {LedR, LedG, LedB}, 24'hFFFFFF);
    chk("async reset enable", enable, 0);
    chk("async reset comm", comm, 0);
    chk("async reset frame_start", frame_start, 0);
    chk("async reset swap_ack", swap_ack, 0);
    chk("async reset busy", busy, 0);
    @(negedge SYS_CLK);
    RST = 1'b1;
    acks = 0;
    for (int i = 0; i < 140; i++) begin
      @(negedge SYS_CLK);
      if (swap_ack) acks++;
    end
    chk("no swap_ack after reset", acks, 0);
    push_rows(3'd0, 24'hFFFFFF);
    check_rows("post-reset front");
    align(8, 4);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    wait_fs(ack);
    chk("post-reset swap_ack", ack, 1);
    push_rows(3'd0, 24'hFFFFFF);
    check_rows("post-reset back");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
